// File: rtl/froc_test_sequencer.sv
// Run-protocol sequencer for the FRoC circuit under test: start pulse, timed run windows
// separated by forced reset phases, and error accounting with the cycle of the first error.
module froc_test_sequencer #(
   parameter int RUN_CYCLES   = 64,
   parameter int RESET_CYCLES = 4,
   parameter int ITERATIONS   = 16,
   parameter int CNT_W        = 16,
   parameter int CYC_W        = 32,
   parameter int IT_W         = $clog2(ITERATIONS + 1)
) (
   input  logic             CLK,
   input  logic             reset,
   input  logic             go,
   input  logic             abort,
   input  logic             dut_error,
   output logic             start,
   output logic             dut_reset,
   output logic             running,
   output logic             done,
   output logic             aborted,
   output logic [IT_W-1:0]  iteration,
   output logic [CNT_W-1:0] error_count,
   output logic             first_error_valid,
   output logic [CYC_W-1:0] first_error_cycle
);

   localparam int WIN_W = $clog2(RUN_CYCLES + 1);
   localparam int RST_W = $clog2(RESET_CYCLES + 1);
   localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(RUN_CYCLES - 1);
   localparam logic [RST_W-1:0] RST_LAST = RST_W'(RESET_CYCLES - 1);
   localparam logic [IT_W-1:0]  IT_LAST  = IT_W'(ITERATIONS - 1);

   typedef enum logic [2:0] {IDLE, START, RUN, RSTPH, DONE} state_t;

   state_t           state;
   logic [CYC_W-1:0] cycle_count;
   logic [WIN_W-1:0] window_count;
   logic [RST_W-1:0] reset_count;

   // Output flags are set on the transition into each state so they track state without decode glitches.
   always_ff @(posedge CLK) begin
      if (reset) begin
         state             <= IDLE;
         start             <= 1'b0;
         dut_reset         <= 1'b0;
         running           <= 1'b0;
         done              <= 1'b0;
         aborted           <= 1'b0;
         iteration         <= '0;
         error_count       <= '0;
         first_error_valid <= 1'b0;
         first_error_cycle <= '0;
         cycle_count       <= '0;
         window_count      <= '0;
         reset_count       <= '0;
      end else begin
         start <= 1'b0;
         case (state)
            IDLE: begin
               if (go) begin
                  state             <= START;
                  start             <= 1'b1;
                  aborted           <= 1'b0;
                  iteration         <= '0;
                  error_count       <= '0;
                  first_error_valid <= 1'b0;
                  first_error_cycle <= '0;
                  cycle_count       <= '0;
                  window_count      <= '0;
               end
            end
            START: begin
               if (abort) begin
                  state   <= DONE;
                  done    <= 1'b1;
                  aborted <= 1'b1;
               end else begin
                  state   <= RUN;
                  running <= 1'b1;
               end
            end
            RUN: begin
               if (dut_error) begin
                  if (error_count != '1) begin
                     error_count <= error_count + CNT_W'(1);
                  end
                  if (!first_error_valid) begin
                     first_error_valid <= 1'b1;
                     first_error_cycle <= cycle_count;
                  end
               end
               cycle_count  <= cycle_count + CYC_W'(1);
               window_count <= window_count + WIN_W'(1);
               if (abort || (window_count == WIN_LAST && iteration == IT_LAST)) begin
                  state   <= DONE;
                  running <= 1'b0;
                  done    <= 1'b1;
                  aborted <= abort;
               end else if (window_count == WIN_LAST) begin
                  state       <= RSTPH;
                  running     <= 1'b0;
                  dut_reset   <= 1'b1;
                  reset_count <= '0;
               end
            end
            RSTPH: begin
               // Abort wins over the phase exit, so an aborted phase leaves iteration untouched.
               if (abort) begin
                  state     <= DONE;
                  dut_reset <= 1'b0;
                  done      <= 1'b1;
                  aborted   <= 1'b1;
               end else if (reset_count == RST_LAST) begin
                  state        <= RUN;
                  dut_reset    <= 1'b0;
                  running      <= 1'b1;
                  iteration    <= iteration + IT_W'(1);
                  window_count <= '0;
               end else begin
                  reset_count <= reset_count + RST_W'(1);
               end
            end
            DONE: begin
               if (!go) begin
                  state <= IDLE;
                  done  <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_froc_test_sequencer.sv
// Bench for froc_test_sequencer: directed and random runs checked every cycle against a
// timeline model (phase and run-cycle index computed arithmetically from cycles since start).
module tb_froc_test_sequencer;

   localparam int R  = 4;
   localparam int S  = 2;
   localparam int IT = 3;
   localparam int MAX_EC = 65535;

   logic        CLK = 1'b0;
   logic        reset, go, abort, dut_error;
   logic        start, dut_reset, running, done, aborted;
   logic [1:0]  iteration;
   logic [15:0] error_count;
   logic        first_error_valid;
   logic [31:0] first_error_cycle;

   logic        go_b;
   logic        start_b, dut_reset_b, running_b, done_b, aborted_b;
   logic [1:0]  iteration_b;
   logic [1:0]  error_count_b;
   logic        first_error_valid_b;
   logic [31:0] first_error_cycle_b;

   int total_checks  = 0;
   int passed_checks = 0;
   int n_start, n_run, n_rst;

   // Model: mode 0 idle, 1 active (m_t cycles since the start cycle), 2 done.
   int m_mode, m_t, m_ec, m_fec, m_iter;
   bit m_fev, m_ab;

   always #5 CLK = ~CLK;

   froc_test_sequencer #(.RUN_CYCLES(R), .RESET_CYCLES(S), .ITERATIONS(IT),
                         .CNT_W(16), .CYC_W(32)) dut_a (
      .CLK(CLK), .reset(reset), .go(go), .abort(abort), .dut_error(dut_error),
      .start(start), .dut_reset(dut_reset), .running(running), .done(done),
      .aborted(aborted), .iteration(iteration), .error_count(error_count),
      .first_error_valid(first_error_valid), .first_error_cycle(first_error_cycle)
   );

   froc_test_sequencer #(.RUN_CYCLES(4), .RESET_CYCLES(2), .ITERATIONS(2),
                         .CNT_W(2), .CYC_W(32)) dut_b (
      .CLK(CLK), .reset(reset), .go(go_b), .abort(1'b0), .dut_error(1'b1),
      .start(start_b), .dut_reset(dut_reset_b), .running(running_b), .done(done_b),
      .aborted(aborted_b), .iteration(iteration_b), .error_count(error_count_b),
      .first_error_valid(first_error_valid_b), .first_error_cycle(first_error_cycle_b)
   );

   function automatic int ph(int t);
      int k, w, p;
      if (t == 0) return 0;
      k = t - 1;
      w = k / (R + S);
      p = k % (R + S);
      if (w > IT - 1 || (w == IT - 1 && p >= R)) return 3;
      return (p < R) ? 1 : 2;
   endfunction

   function automatic int run_idx(int t);
      return ((t - 1) / (R + S)) * R + (t - 1) % (R + S);
   endfunction

   function automatic int cur_phase();
      return (m_mode == 1) ? ph(m_t) : -1;
   endfunction

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_checks++;
      assert (obs === exp) passed_checks++;
      else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic model_edge(input bit r, input bit g, input bit a, input bit e);
      int cur;
      if (r) begin
         m_mode = 0; m_t = 0; m_ec = 0; m_fev = 0; m_fec = 0; m_iter = 0; m_ab = 0;
      end else if (m_mode == 0) begin
         if (g) begin
            m_mode = 1; m_t = 0; m_ec = 0; m_fev = 0; m_fec = 0; m_iter = 0; m_ab = 0;
         end
      end else if (m_mode == 1) begin
         cur = ph(m_t);
         if (cur == 1 && e) begin
            if (m_ec < MAX_EC) m_ec++;
            if (!m_fev) begin
               m_fev = 1;
               m_fec = run_idx(m_t);
            end
         end
         if (a) begin
            m_mode = 2;
            m_ab   = 1;
         end else begin
            m_t++;
            if (ph(m_t) == 3) m_mode = 2;
            else m_iter = (m_t - 1) / (R + S);
         end
      end else if (!g) begin
         m_mode = 0;
      end
   endtask

   task automatic apply_stimulus(input bit r, input bit g, input bit a, input bit e);
      int cur;
      reset = r; go = g; abort = a; dut_error = e;
      @(posedge CLK);
      #1;
      model_edge(r, g, a, e);
      cur = cur_phase();
      check_output("start", start, (cur == 0));
      check_output("running", running, (cur == 1));
      check_output("dut_reset", dut_reset, (cur == 2));
      check_output("done", done, (m_mode == 2));
      check_output("iteration", iteration, m_iter);
      check_output("error_count", error_count, m_ec);
      check_output("first_error_valid", first_error_valid, m_fev);
      check_output("first_error_cycle", first_error_cycle, m_fec);
      if (m_mode == 2 || r) check_output("aborted", aborted, m_ab);
      check_output("exclusive", 32'(start) + 32'(running) + 32'(dut_reset) + 32'(done) <= 1, 1);
      if (start === 1'b1) n_start++;
      if (running === 1'b1) n_run++;
      if (dut_reset === 1'b1) n_rst++;
   endtask

   function automatic bit err_pattern();
      int cur;
      cur = cur_phase();
      if (cur == 2) return 1'b1;
      if (cur == 1) begin
         case (run_idx(m_t))
            5, 6, 11: return 1'b1;
            default:  return 1'b0;
         endcase
      end
      return 1'b0;
   endfunction

   initial begin
      reset = 1'b1; go = 1'b0; abort = 1'b0; dut_error = 1'b0; go_b = 1'b0;
      apply_stimulus(1, 0, 0, 0);
      apply_stimulus(1, 0, 0, 0);
      check_output("reset_done_b", done_b, 0);
      check_output("reset_ec_b", error_count_b, 0);

      // Saturation on the narrow-counter instance with dut_error tied high.
      go_b = 1'b1;
      for (int i = 0; i < 40 && done_b !== 1'b1; i++) apply_stimulus(0, 0, 0, 0);
      check_output("sat_done", done_b, 1);
      check_output("sat_error_count", error_count_b, 3);
      check_output("sat_first_valid", first_error_valid_b, 1);
      check_output("sat_first_cycle", first_error_cycle_b, 0);
      check_output("sat_iteration", iteration_b, 1);
      go_b = 1'b0;

      $display("[TB] nominal run");
      n_start = 0; n_run = 0; n_rst = 0;
      apply_stimulus(0, 1, 0, 0);
      for (int i = 0; i < 40 && m_mode != 2; i++) apply_stimulus(0, 0, 0, 0);
      check_output("nom_done", done, 1);
      check_output("nom_start_pulses", n_start, 1);
      check_output("nom_run_cycles", n_run, R * IT);
      check_output("nom_reset_cycles", n_rst, S * (IT - 1));
      check_output("nom_error_count", error_count, 0);
      check_output("nom_first_valid", first_error_valid, 0);
      apply_stimulus(0, 0, 0, 0);

      $display("[TB] error accounting");
      apply_stimulus(0, 1, 0, 0);
      for (int i = 0; i < 40 && m_mode == 1; i++) apply_stimulus(0, 0, 0, err_pattern());
      check_output("err_error_count", error_count, 3);
      check_output("err_first_cycle", first_error_cycle, 5);
      apply_stimulus(0, 0, 0, 0);

      $display("[TB] abort in reset phase");
      apply_stimulus(0, 1, 0, 0);
      for (int i = 0; i < 40 && !(m_mode == 1 && ph(m_t) == 2 && (m_t - 1) % (R + S) == R + 1); i++)
         apply_stimulus(0, 0, 0, 0);
      apply_stimulus(0, 0, 1, 0);
      check_output("abort_rst_done", done, 1);
      check_output("abort_rst_aborted", aborted, 1);
      check_output("abort_rst_iteration", iteration, 0);
      check_output("abort_rst_dut_reset", dut_reset, 0);
      apply_stimulus(0, 0, 0, 0);

      $display("[TB] abort on last run cycle with error");
      apply_stimulus(0, 1, 0, 0);
      for (int i = 0; i < 40 && !(m_mode == 1 && ph(m_t) == 1 && run_idx(m_t) == R * IT - 1); i++)
         apply_stimulus(0, 0, 0, 0);
      apply_stimulus(0, 0, 1, 1);
      check_output("abort_last_error_count", error_count, 1);
      check_output("abort_last_aborted", aborted, 1);
      apply_stimulus(0, 0, 0, 0);

      $display("[TB] go held through done");
      n_start = 0;
      for (int i = 0; i < 40; i++) apply_stimulus(0, 1, 0, ($urandom % 3) == 0);
      check_output("held_start_pulses", n_start, 1);
      check_output("held_done", done, 1);
      apply_stimulus(0, 0, 0, 0);
      check_output("drop_go_done", done, 0);
      apply_stimulus(0, 1, 0, 0);
      check_output("rego_error_count", error_count, 0);
      for (int i = 0; i < 40 && m_mode != 2; i++) apply_stimulus(0, 0, 0, ($urandom % 4) == 0);
      apply_stimulus(0, 0, 0, 0);

      $display("[TB] mid-test reset");
      apply_stimulus(0, 1, 0, 1);
      for (int i = 0; i < 40 && !(m_mode == 1 && ph(m_t) == 1 && (m_t - 1) / (R + S) == 1); i++)
         apply_stimulus(0, 0, 0, 1);
      apply_stimulus(1, 0, 0, 1);
      check_output("midreset_running", running, 0);
      check_output("midreset_error_count", error_count, 0);
      check_output("midreset_iteration", iteration, 0);
      n_run = 0;
      apply_stimulus(0, 1, 0, 0);
      for (int i = 0; i < 40 && m_mode != 2; i++) apply_stimulus(0, 0, 0, 0);
      check_output("after_reset_run_cycles", n_run, R * IT);
      check_output("after_reset_iteration", iteration, IT - 1);

      $display("[TB] random traffic");
      for (int i = 0; i < 600; i++) begin
         bit g;
         g = (m_mode == 2) ? ($urandom % 2 == 0) : ($urandom % 4 == 0);
         apply_stimulus(($urandom % 150) == 0, g, ($urandom % 30) == 0, ($urandom % 3) == 0);
      end

      $display("%0d/%0d checks passed", passed_checks, total_checks);
      $finish;
   end

endmodule

// File: doc/froc_test_sequencer.md
Name: froc_test_sequencer

Overview:
- Synthesizable sequencer for the FRoC circuit under test.
- On a host `go`, it issues the `start` pulse and runs the DUT for a fixed number of cycles. It then forces a reset phase and repeats this for a set number of iterations before raising `done`.
- Accumulates the DUT `error` indications and reports the cycle of the first error.
- Replaces bench-driven start/done generation so the same run protocol executes on hardware and in simulation.

Parameters:
- RUN_CYCLES, 64: cycles per run window. Must be ≥1.
- RESET_CYCLES, 4: cycles per forced reset phase. Must be ≥1.
- ITERATIONS, 16: number of run windows per test. Must be ≥1.
- CNT_W, 16: width of the error counter.
- CYC_W, 32: width of the global run-cycle counter.
- IT_W, $clog2(ITERATIONS+1): width of the iteration index.

Ports:
- CLK  in  1  clock.
- reset  in  1  synchronous, active-high.
- go  in  1  host request. Level-sampled in IDLE.
- abort  in  1  host abort. Sampled in START/RUN/RSTPH.
- dut_error  in  1  DUT error flag. Sampled only in RUN.
- start  out  1  one-cycle pulse to the DUT at test begin.
- dut_reset  out  1  forces the DUT into its reset phase.
- running  out  1  high in RUN.
- done  out  1  high in DONE.
- aborted  out  1  test ended by abort. Valid while `done` is high.
- iteration  out  IT_W  index of the current run window, starting at 0.
- error_count  out  CNT_W  errors seen in RUN cycles. Saturates at all-ones.
- first_error_valid  out  1  at least one error seen.
- first_error_cycle  out  CYC_W  global run-cycle index of the first error.

Behaviour:
- Reset:
  - State goes to IDLE.
  - All outputs are 0, and all counters are 0.
  - Reset has priority over every other input, including mid-test. The test is dropped and nothing is reported.
- States: IDLE, START, RUN, RSTPH, DONE. Outputs are registered.
- IDLE:
  - When `go`=1 is sampled: next state is START. Clear `error_count`, `first_error_*`, `iteration`, `aborted`, the global cycle counter and the window counter.
- START:
  - `start`=1 for exactly one cycle. Next state is RUN.
  - Latency: `go` high at edge N gives `start` high in cycle N+1 and `running` high in cycle N+2.
- RUN:
  - `running`=1.
  - Each cycle:
    - If `dut_error`=1: increment `error_count`, saturating.
    - If that error is the first: set `first_error_valid` and latch the current global cycle value into `first_error_cycle`.
    - Increment the global cycle counter (wraps at 2^CYC_W) and the window counter.
  - An error on the final window cycle is counted.
  - After RUN_CYCLES cycles:
    - If `iteration` == ITERATIONS-1: next state is DONE.
    - Otherwise: next state is RSTPH.
- RSTPH:
  - `dut_reset`=1 for exactly RESET_CYCLES cycles. `dut_error` is ignored.
  - The global cycle counter holds.
  - On exit: increment `iteration`, clear the window counter, and return to RUN. No new `start` pulse is issued.
- DONE:
  - `done`=1. All result outputs hold.
  - Returns to IDLE only when `go`=0 is sampled. Results stay valid until the next IDLE→START transition.
  - `go` held high therefore does not retrigger a test.
- abort:
  - Priority is below reset and above all other transitions.
  - In START, RUN or RSTPH: next state is DONE with `aborted`=1.
  - In that abort cycle: a RUN-state `dut_error` is still counted. `start` and `dut_reset` drop the cycle after the abort is sampled.
  - Ignored in IDLE and DONE.
- Simultaneous events:
  - `abort` and the window end in the same cycle: go to DONE with `aborted`=1.
  - `dut_error` and the saturation limit: `error_count` stays at all-ones.
- Invariants:
  - `running`, `dut_reset`, `start` and `done` are mutually exclusive.
  - `iteration` never exceeds ITERATIONS-1.
  - Total cycles in RUN per completed test = RUN_CYCLES×ITERATIONS.
  - Total cycles with `dut_reset` high = RESET_CYCLES×(ITERATIONS-1).

Test Plan:
- Nominal run:
  - Stimulus: RUN_CYCLES=4, RESET_CYCLES=2, ITERATIONS=3. `go` pulsed for 1 cycle, no errors.
  - Required: 1 `start` pulse; `running` high 3×4 cycles; `dut_reset` high 2 cycles after windows 0 and 1.
  - Required at completion: `done`=1, `error_count`=0, `first_error_valid`=0.
- Error accounting:
  - Stimulus: same config, `dut_error` high on global run-cycles 5, 6 and 11 (11 is the final cycle), plus high throughout every RSTPH cycle.
  - Required: `error_count`=3, `first_error_cycle`=5.
- Saturation:
  - Stimulus: CNT_W=2, `dut_error` tied high, RUN_CYCLES=4, ITERATIONS=2.
  - Required: `error_count`=3, `first_error_cycle`=0.
- Abort:
  - Stimulus: `abort` asserted on the 2nd RSTPH cycle.
  - Required: DONE next cycle, `aborted`=1, `iteration`=0, `dut_reset` low the following cycle.
  - Stimulus: `abort` together with the last RUN cycle and an error.
  - Required: error counted, `aborted`=1.
- Go handshake:
  - Stimulus: `go` held high through DONE.
  - Required: stays in DONE, no second `start`.
  - Stimulus: drop `go`, then re-raise it.
  - Required: IDLE, then a new test with counters cleared on START.
- Mid-test reset:
  - Stimulus: `reset` asserted in RUN of window 1.
  - Required: next cycle IDLE with all outputs 0. A subsequent `go` runs the full 3 windows.
